// File: rtl/bash_dispatcher.sv
// bash_dispatcher
//   Fetches one command line from the console, decodes the first token,
//   starts the matching handler (echo/help/clear) and streams that handler's
//   response bytes back to the console through a 16-entry FIFO. Unknown
//   commands answer "unknown". Every command ends with a one-cycle in_solved
//   pulse, which the console must acknowledge with out_solved.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   out_newASCII_ready       console has a completed line pending
//   out_lineLen[5:0]         pending line length (0..32)
//   lineOut[7:0]             current command character
//   lineOut_nextASCII        pulse: advance console to next character
//   in_newASCII_ready        response byte valid (FIFO not empty)
//   lineIn[7:0]              response byte (FIFO head), 0x00 ends a line
//   lineIn_nextASCII         console pops lineIn
//   in_solved                pulse: command finished
//   out_solved               console acknowledge of in_solved
//   hdl_start[2:0]           one-hot start: bit0 echo, bit1 help, bit2 clear
//   hdl_arg_len[5:0]         argument length
//   hdl_arg_addr[4:0]        argument byte index
//   hdl_arg_data[7:0]        argument byte, 0x00 past the end
//   resp_valid, resp_data    handler response byte stream
//   resp_ready               FIFO can take a handler byte
//   hdl_done                 pulse: active handler finished
//   busy                     high whenever not IDLE
module bash_dispatcher (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_newASCII_ready,
  input  logic [5:0] out_lineLen,
  input  logic [7:0] lineOut,
  output logic       lineOut_nextASCII,
  output logic       in_newASCII_ready,
  output logic [7:0] lineIn,
  input  logic       lineIn_nextASCII,
  output logic       in_solved,
  input  logic       out_solved,
  output logic [2:0] hdl_start,
  output logic [5:0] hdl_arg_len,
  input  logic [4:0] hdl_arg_addr,
  output logic [7:0] hdl_arg_data,
  input  logic       resp_valid,
  input  logic [7:0] resp_data,
  output logic       resp_ready,
  input  logic       hdl_done,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_DRAIN    = 3'd4,
    S_SOLVE    = 3'd5,
    S_WAIT_ACK = 3'd6
  } state_t;

  state_t      state_r;
  logic [5:0]  len_r;
  logic [5:0]  idx_r;
  logic        phase_r;        // 0: capture + pulse, 1: gap cycle
  logic [7:0]  cmd_buf_r [32];
  logic [4:0]  arg_base_r;
  logic [5:0]  arg_len_r;
  logic        last_nz_r;      // last handler byte pushed was non-zero
  logic        term_pend_r;    // a 0x00 terminator still has to be pushed
  logic        next_ascii_r;
  logic        solved_r;
  logic [2:0]  start_r;

  logic [7:0]  fifo_r [16];
  logic [3:0]  wr_ptr_r;
  logic [3:0]  rd_ptr_r;
  logic [4:0]  count_r;

  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        pop_s;
  logic        push_s;
  logic [7:0]  push_data_s;
  logic        accept_s;
  logic        bulk_s;
  logic        fetch_cap_s;
  logic [5:0]  tok_len_s;
  logic        has_space_s;
  logic [2:0]  match_s;
  logic [5:0]  base_s;
  logic [4:0]  arg_idx_s;

  // Bytes of the fixed "unknown",0x00 reply
  function automatic logic [7:0] unk_byte(input logic [2:0] k);
    case (k)
      3'd0:    unk_byte = 8'h75;
      3'd1:    unk_byte = 8'h6E;
      3'd2:    unk_byte = 8'h6B;
      3'd3:    unk_byte = 8'h6E;
      3'd4:    unk_byte = 8'h6F;
      3'd5:    unk_byte = 8'h77;
      3'd6:    unk_byte = 8'h6E;
      default: unk_byte = 8'h00;
    endcase
  endfunction

  assign fifo_empty_s      = (count_r == 5'd0);
  assign fifo_full_s       = (count_r == 5'd16);
  assign pop_s             = lineIn_nextASCII && !fifo_empty_s;
  assign accept_s          = (state_r == S_EXEC) && resp_valid && !fifo_full_s;
  // The FIFO is always empty in DECODE, so the whole reply fits in one cycle
  assign bulk_s            = (state_r == S_DECODE) && (match_s == 3'b000);
  assign fetch_cap_s       = (state_r == S_FETCH) && !phase_r && (idx_r != len_r);

  assign lineOut_nextASCII = next_ascii_r;
  assign in_solved         = solved_r;
  assign hdl_start         = start_r;
  assign hdl_arg_len       = arg_len_r;
  assign in_newASCII_ready = !fifo_empty_s;
  assign lineIn            = fifo_empty_s ? 8'h00 : fifo_r[rd_ptr_r];
  assign resp_ready        = (state_r == S_EXEC) && !fifo_full_s;
  assign busy              = (state_r != S_IDLE);

  // Token scan: descending loop so the lowest-index space wins
  always_comb begin
    tok_len_s   = len_r;
    has_space_s = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if ((6'(i) < len_r) && (cmd_buf_r[i] == 8'h20)) begin
        tok_len_s   = 6'(i);
        has_space_s = 1'b1;
      end else begin
        tok_len_s   = tok_len_s;
        has_space_s = has_space_s;
      end
    end
    if ((tok_len_s == 6'd4) &&
        ({cmd_buf_r[0], cmd_buf_r[1], cmd_buf_r[2], cmd_buf_r[3]} == 32'h6563_686F)) begin
      match_s = 3'b001;
    end else if ((tok_len_s == 6'd4) &&
        ({cmd_buf_r[0], cmd_buf_r[1], cmd_buf_r[2], cmd_buf_r[3]} == 32'h6865_6C70)) begin
      match_s = 3'b010;
    end else if ((tok_len_s == 6'd5) &&
        ({cmd_buf_r[0], cmd_buf_r[1], cmd_buf_r[2], cmd_buf_r[3], cmd_buf_r[4]} == 40'h63_6C65_6172)) begin
      match_s = 3'b100;
    end else begin
      match_s = 3'b000;
    end
    if (has_space_s) begin
      base_s = tok_len_s + 6'd1;
    end else begin
      base_s = tok_len_s;
    end
  end

  // Argument read port; base+addr stays below 32 whenever addr < arg_len
  always_comb begin
    arg_idx_s = arg_base_r + hdl_arg_addr;
    if ({1'b0, hdl_arg_addr} < arg_len_r) begin
      hdl_arg_data = cmd_buf_r[arg_idx_s];
    end else begin
      hdl_arg_data = 8'h00;
    end
  end

  // Single-byte FIFO push source: handler data in EXEC, terminator in DRAIN
  always_comb begin
    if (accept_s) begin
      push_s      = 1'b1;
      push_data_s = resp_data;
    end else if ((state_r == S_DRAIN) && term_pend_r && !fifo_full_s) begin
      push_s      = 1'b1;
      push_data_s = 8'h00;
    end else begin
      push_s      = 1'b0;
      push_data_s = 8'h00;
    end
  end

  // Command line storage, captured during FETCH phase 0
  always_ff @(posedge clk) begin
    if (fetch_cap_s) begin
      cmd_buf_r[idx_r[4:0]] <= lineOut;
    end
  end

  // Response FIFO data array
  always_ff @(posedge clk) begin
    if (bulk_s) begin
      for (int i = 0; i < 8; i++) begin
        fifo_r[wr_ptr_r + 4'(i)] <= unk_byte(3'(i));
      end
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= push_data_s;
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= 4'd0;
      rd_ptr_r <= 4'd0;
      count_r  <= 5'd0;
    end else begin
      if (bulk_s) begin
        wr_ptr_r <= wr_ptr_r + 4'd8;
      end else if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 4'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 4'd1;
      end
      count_r <= count_r + (bulk_s ? 5'd8 : {4'd0, push_s}) - {4'd0, pop_s};
    end
  end

  // Command sequencing FSM with registered pulse outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      len_r        <= 6'd0;
      idx_r        <= 6'd0;
      phase_r      <= 1'b0;
      arg_base_r   <= 5'd0;
      arg_len_r    <= 6'd0;
      last_nz_r    <= 1'b0;
      term_pend_r  <= 1'b0;
      next_ascii_r <= 1'b0;
      solved_r     <= 1'b0;
      start_r      <= 3'b000;
    end else begin
      next_ascii_r <= 1'b0;
      solved_r     <= 1'b0;
      start_r      <= 3'b000;
      if (accept_s) begin
        last_nz_r <= (resp_data != 8'h00);
      end
      case (state_r)
        S_IDLE: begin
          if (out_newASCII_ready) begin
            len_r       <= (out_lineLen > 6'd32) ? 6'd32 : out_lineLen;
            idx_r       <= 6'd0;
            phase_r     <= 1'b0;
            last_nz_r   <= 1'b0;
            term_pend_r <= 1'b0;
            arg_len_r   <= 6'd0;
            state_r     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!phase_r) begin
            if (idx_r == len_r) begin
              if (len_r == 6'd0) begin
                solved_r <= 1'b1;
                state_r  <= S_SOLVE;
              end else begin
                state_r  <= S_DECODE;
              end
            end else begin
              next_ascii_r <= 1'b1;
              phase_r      <= 1'b1;
            end
          end else begin
            phase_r <= 1'b0;
            idx_r   <= idx_r + 6'd1;
          end
        end
        S_DECODE: begin
          arg_base_r <= base_s[4:0];
          arg_len_r  <= len_r - base_s;
          if (match_s != 3'b000) begin
            start_r <= match_s;
            state_r <= S_EXEC;
          end else begin
            state_r <= S_DRAIN;
          end
        end
        S_EXEC: begin
          if (hdl_done) begin
            // A byte arriving with hdl_done decides whether a terminator is needed
            term_pend_r <= accept_s ? (resp_data != 8'h00) : last_nz_r;
            state_r     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (term_pend_r) begin
            if (!fifo_full_s) begin
              term_pend_r <= 1'b0;
            end
          end else if (fifo_empty_s) begin
            solved_r <= 1'b1;
            state_r  <= S_SOLVE;
          end
        end
        S_SOLVE: begin
          state_r <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (out_solved) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bash_dispatcher.sv
`timescale 1ns/1ps
module tb_bash_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_newASCII_ready = 1'b0;
  logic [5:0] out_lineLen = 6'd0;
  logic [7:0] lineOut = 8'h00;
  logic       lineOut_nextASCII;
  logic       in_newASCII_ready;
  logic [7:0] lineIn;
  logic       lineIn_nextASCII = 1'b0;
  logic       in_solved;
  logic       out_solved = 1'b0;
  logic [2:0] hdl_start;
  logic [5:0] hdl_arg_len;
  logic [4:0] hdl_arg_addr = 5'd0;
  logic [7:0] hdl_arg_data;
  logic       resp_valid = 1'b0;
  logic [7:0] resp_data = 8'h00;
  logic       resp_ready;
  logic       hdl_done = 1'b0;
  logic       busy;

  bash_dispatcher dut (
    .clk(clk), .rst(rst),
    .out_newASCII_ready(out_newASCII_ready), .out_lineLen(out_lineLen),
    .lineOut(lineOut), .lineOut_nextASCII(lineOut_nextASCII),
    .in_newASCII_ready(in_newASCII_ready), .lineIn(lineIn),
    .lineIn_nextASCII(lineIn_nextASCII), .in_solved(in_solved),
    .out_solved(out_solved), .hdl_start(hdl_start), .hdl_arg_len(hdl_arg_len),
    .hdl_arg_addr(hdl_arg_addr), .hdl_arg_data(hdl_arg_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .hdl_done(hdl_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] line;  int line_len;
    logic [2:0]   start; int arg_len;
    logic [255:0] arg;
    logic [255:0] resp;  int resp_len;
    logic [255:0] exp;   int exp_len;
  } vec_t;

  vec_t vecs [10];

  int checks = 0;
  int errors = 0;

  // console / handler monitor state
  logic [7:0] feed_buf [32];
  int         feed_pos = 0;
  int         pulse_cnt = 0, gap_err = 0, start_cnt = 0, solved_cnt = 0;
  int         cyc = 0, busy_rise = 0, solved_cyc = 0;
  logic [2:0] start_seen = 3'b000;
  logic       prev_pulse = 1'b0, prev_busy = 1'b0;
  logic       sink_en = 1'b1;
  logic [7:0] rx_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pk(input string s);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < s.len() && i < 32; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  function automatic vec_t mk(input string line, input logic [2:0] st, input int al,
                              input string arg, input string resp, input int rz,
                              input string ex, input int ez);
    vec_t v;
    v.line = pk(line);  v.line_len = line.len();
    v.start = st;       v.arg_len = al;  v.arg = pk(arg);
    v.resp = pk(resp);  v.resp_len = resp.len() + rz;
    v.exp = pk(ex);     v.exp_len = ex.len() + ez;
    return v;
  endfunction

  // Console model + observers, all evaluated on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (lineOut_nextASCII) begin
        pulse_cnt++;
        if (prev_pulse) gap_err++;
        feed_pos++;
        lineOut = (feed_pos < 32) ? feed_buf[feed_pos] : 8'h00;
      end
      prev_pulse = lineOut_nextASCII;
      if (hdl_start != 3'b000) begin
        start_seen = start_seen | hdl_start;
        start_cnt++;
      end
      if (in_solved) begin
        solved_cnt++;
        solved_cyc = cyc;
      end
      if (busy && !prev_busy) busy_rise = cyc;
      prev_busy = busy;
      if (sink_en && in_newASCII_ready) begin
        rx_q.push_back(lineIn);
        lineIn_nextASCII = 1'b1;
      end else begin
        lineIn_nextASCII = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_line(input logic [255:0] line, input int n);
    int k;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) feed_buf[i] = line[8*i +: 8];
    feed_pos = 0; lineOut = feed_buf[0];
    pulse_cnt = 0; gap_err = 0; start_cnt = 0; solved_cnt = 0;
    start_seen = 3'b000; prev_pulse = 1'b0; rx_q.delete();
    out_lineLen = 6'(n);
    out_newASCII_ready = 1'b1;
    k = 0;
    while (!busy && k < 20) begin @(posedge clk); #1; k++; end
    chk("busy_on_start", busy, 1);
    out_newASCII_ready = 1'b0;
  endtask

  task automatic wait_progress();
    int k = 0;
    while (start_seen == 3'b000 && solved_cnt == 0 && k < 400) begin @(posedge clk); #1; k++; end
    chk("progress_timeout", k < 400, 1);
  endtask

  task automatic wait_solved();
    int k = 0;
    while (solved_cnt == 0 && k < 600) begin @(posedge clk); #1; k++; end
    chk("solved_timeout", k < 600, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic done);
    int k = 0;
    @(negedge clk);
    while (!resp_ready && k < 200) begin @(negedge clk); k++; end
    chk("resp_ready_timeout", k < 200, 1);
    resp_valid = 1'b1; resp_data = d; hdl_done = done;
    @(negedge clk);
    resp_valid = 1'b0; hdl_done = 1'b0;
  endtask

  task automatic send_done_only();
    @(negedge clk); hdl_done = 1'b1;
    @(negedge clk); hdl_done = 1'b0;
  endtask

  task automatic ack();
    chk("busy_in_wait_ack", busy, 1);
    @(posedge clk); #1; out_solved = 1'b1;
    @(posedge clk); #1; out_solved = 1'b0;
    chk("idle_after_ack", busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    string nm;
    nm = $sformatf("v%0d", id);
    start_line(v.line, v.line_len);
    wait_progress();
    if (v.start != 3'b000) begin
      chk({nm, "_arg_len"}, hdl_arg_len, v.arg_len);
      for (int i = 0; i <= v.arg_len; i++) begin
        hdl_arg_addr = 5'(i); #1;
        chk({nm, "_arg_byte"}, hdl_arg_data, (i < v.arg_len) ? v.arg[8*i +: 8] : 8'h00);
      end
      if (v.resp_len == 0) send_done_only();
      else for (int i = 0; i < v.resp_len; i++) send_byte(v.resp[8*i +: 8], i == v.resp_len - 1);
    end
    wait_solved();
    chk({nm, "_start"}, start_seen, v.start);
    chk({nm, "_start_pulses"}, start_cnt, (v.start != 3'b000) ? 1 : 0);
    chk({nm, "_solved_pulses"}, solved_cnt, 1);
    chk({nm, "_fetch_pulses"}, pulse_cnt, v.line_len);
    chk({nm, "_fetch_gap"}, gap_err, 0);
    chk({nm, "_rx_len"}, rx_q.size(), v.exp_len);
    for (int i = 0; i < v.exp_len && i < rx_q.size(); i++)
      chk({nm, "_rx_byte"}, rx_q[i], v.exp[8*i +: 8]);
    if (v.line_len == 0) begin
      chk({nm, "_solve_latency_ok"}, ((solved_cyc - busy_rise) >= 1) && ((solved_cyc - busy_rise) <= 2), 1);
    end
    ack();
  endtask

  initial begin
    int k;
    vecs[0] = mk("echo hi",   3'b001, 2, "hi",  "hi",  0, "hi",      1);
    vecs[1] = mk("help",      3'b010, 0, "",    "hlp", 0, "hlp",     1);
    vecs[2] = mk("clear",     3'b100, 0, "",    "",    0, "",        0);
    vecs[3] = mk("foo",       3'b000, 0, "",    "",    0, "unknown", 1);
    vecs[4] = mk("",          3'b000, 0, "",    "",    0, "",        0);
    vecs[5] = mk("help x",    3'b010, 1, "x",   "a",   1, "a",       1);
    vecs[6] = mk("Echo hi",   3'b000, 0, "",    "",    0, "unknown", 1);
    vecs[7] = mk("echoes",    3'b000, 0, "",    "",    0, "unknown", 1);
    vecs[8] = mk("clear a b", 3'b100, 3, "a b", "ok",  0, "ok",      1);
    vecs[9] = mk(" echo",     3'b000, 0, "",    "",    0, "unknown", 1);

    // reset state, before any clock edge
    #1;
    chk("reset_outputs",
        {busy, lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved, hdl_start, resp_ready, hdl_arg_len},
        64'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // handler strobes in IDLE are ignored
    @(negedge clk); resp_valid = 1'b1; resp_data = 8'h55; hdl_done = 1'b1;
    chk("resp_ready_idle", resp_ready, 0);
    @(negedge clk); resp_valid = 1'b0; hdl_done = 1'b0;
    @(posedge clk); #1;
    chk("idle_ignore_fifo", in_newASCII_ready, 0);
    chk("idle_ignore_busy", busy, 0);

    for (int v = 0; v < 10; v++) run_vec(vecs[v], v);

    // FIFO backpressure and pointer wrap: 20 bytes with the console stalled
    sink_en = 1'b0;
    start_line(pk("echo x"), 6);
    wait_progress();
    chk("bp_start", start_seen, 3'b001);
    for (int i = 0; i < 16; i++) send_byte(8'h41 + 8'(i), 1'b0);
    @(negedge clk);
    chk("bp_resp_ready_full", resp_ready, 0);
    chk("bp_fifo_valid", in_newASCII_ready, 1);
    chk("bp_head", lineIn, 8'h41);
    sink_en = 1'b1;
    for (int i = 16; i < 20; i++) send_byte(8'h41 + 8'(i), i == 19);
    wait_solved();
    chk("bp_rx_len", rx_q.size(), 21);
    for (int i = 0; i < 20 && i < rx_q.size(); i++) chk("bp_rx_byte", rx_q[i], 8'h41 + 8'(i));
    if (rx_q.size() > 20) chk("bp_rx_term", rx_q[20], 8'h00);
    chk("bp_solved_pulses", solved_cnt, 1);
    ack();

    // asynchronous reset in the middle of FETCH at idx 3
    start_line(pk("echo hi"), 7);
    k = 0;
    while (pulse_cnt < 3 && k < 100) begin @(posedge clk); #1; k++; end
    chk("rst_fetch_reach_idx3", pulse_cnt, 3);
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("rst_mid_fetch_outputs",
        {busy, lineOut_nextASCII, in_newASCII_ready, lineIn, in_solved, hdl_start, resp_ready, hdl_arg_len},
        64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_solved", solved_cnt, 0);
    chk("rst_idle", busy, 0);
    run_vec(vecs[0], 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
